world_scan_sequencer: RTL
=========================

WORLD_SCAN_SEQUENCER -- requirements
Module: world_scan_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 2: cycles write_flag is held high per grid location; legal range 1..15.
REQ-002 SHALL take X_bits, Y_bits, PIXELS_X and PIXELS_Y from params.sv.
REQ-003 Clk  in  1  single system clock; every flop is rising-edge Clk.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin a full grid sweep.
REQ-006 pause  in  1  level; freezes the sweep while high.
REQ-007 abort  in  1  level; cancels any sweep in progress.
REQ-008 rd_x / rd_y  out  X_bits / Y_bits  sugar-map read address.
REQ-009 rd_sugar  in  1  sugar-map read data, valid one cycle after its address.
REQ-010 write_flag  out  1  global location-write strobe to all ants.
REQ-011 writeLoc_x / writeLoc_y  out  X_bits / Y_bits  location being written.
REQ-012 writeLoc_sugar  out  1  sugar bit for writeLoc.
REQ-013 busy  out  1  high while the sweep is outside IDLE.
REQ-014 done  out  1  one-cycle pulse when a sweep completes.

Function
REQ-015 SHALL implement states IDLE, FETCH, WRITE and DONE.
REQ-016 IDLE: start=1 -> FETCH; x=0, y=0; busy rises next cycle.
REQ-017 FETCH: SHALL last exactly 1 cycle with rd_x=x and rd_y=y, then go to WRITE.
REQ-018 On FETCH->WRITE, rd_sugar SHALL be latched into writeLoc_sugar, and x/y into writeLoc_x/writeLoc_y.
REQ-019 WRITE: write_flag=1 for exactly HOLD_CYCLES cycles; writeLoc_x, writeLoc_y and writeLoc_sugar stable throughout.
REQ-020 Last WRITE cycle at a non-final location: advance in raster order (x+1; at x=PIXELS_X-1, x=0 and y+1) -> FETCH.
REQ-021 Last WRITE cycle at the final location (PIXELS_X-1, PIXELS_Y-1): go to DONE; counters do not advance.
REQ-022 DONE: done=1 for one cycle, then IDLE.
REQ-023 Per-location cost SHALL be 1+HOLD_CYCLES cycles; a full sweep SHALL be PIXELS_X*PIXELS_Y*(1+HOLD_CYCLES)+1 cycles from the start edge to done.
REQ-024 write_flag SHALL be 0 in every state except WRITE, with at least one low cycle (FETCH) between locations.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 pause=1: state, counters and hold count freeze; write_flag forced 0; resume continues the remaining hold cycles at the same location.
REQ-027 abort=1 SHALL take priority over pause and start: next cycle IDLE, write_flag=0, busy=0, no done pulse.
REQ-028 start and abort in the same IDLE cycle SHALL leave the block in IDLE.
REQ-029 Counters SHALL never exceed PIXELS_X-1 / PIXELS_Y-1; no X_bits/Y_bits wrap is used.

Reset
REQ-030 Reset low SHALL asynchronously force IDLE and clear x, y, hold count and all outputs to 0, including mid-sweep.
REQ-031 After Reset releases, the block SHALL wait for a fresh start.

Configuration
REQ-032 With SCAN_FRAME_COUNT_EN defined, SHALL add output sweep_count [15:0]: reset 0, +1 on each done pulse, wraps 0xFFFF->0, unchanged by abort.
REQ-033 Without SCAN_FRAME_COUNT_EN, the port and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-034 HOLD_CYCLES=2; start at T -> FETCH at T+1 with rd=(0,0); write_flag high T+2..T+3 with writeLoc=(0,0); FETCH (1,0) at T+4.
REQ-035 Sugar map with 1 only at (78,58) -> over the full sweep, writeLoc_sugar=1 only while writeLoc=(78,58); done exactly once at T+57601.
REQ-036 Row wrap -> after (PIXELS_X-1,0), next writeLoc=(0,1); last location written is (PIXELS_X-1,PIXELS_Y-1).
REQ-037 pause high 5 cycles during the first WRITE cycle of (3,0) -> write_flag low 5 cycles, then exactly 1 more high cycle at (3,0); done delayed by 5 cycles.
REQ-038 abort mid-sweep at (10,2), then Reset pulse mid-sweep -> IDLE next cycle; write_flag=0, busy=0, no done pulse, and start during abort ignored; on Reset, all outputs 0 immediately.
REQ-039 With SCAN_FRAME_COUNT_EN: three complete sweeps plus one aborted sweep -> sweep_count=3.

Source files
------------

// File: rtl/params.sv
// rtl/params.sv - world grid geometry shared by the world modules
package params;
    localparam int X_bits   = 8;
    localparam int Y_bits   = 7;
    localparam int PIXELS_X = 160;
    localparam int PIXELS_Y = 120;
endpackage

// File: rtl/world_scan_sequencer.sv
// rtl/world_scan_sequencer.sv - raster sweep of the sugar map broadcasting each location to all ants; optional SCAN_FRAME_COUNT_EN adds sweep_count
module world_scan_sequencer
    import params::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    output logic [X_bits-1:0] rd_x,
    output logic [Y_bits-1:0] rd_y,
    input  logic              rd_sugar,
    output logic              write_flag,
    output logic [X_bits-1:0] writeLoc_x,
    output logic [Y_bits-1:0] writeLoc_y,
    output logic              writeLoc_sugar,
    output logic              busy,
    output logic              done
`ifdef SCAN_FRAME_COUNT_EN
    ,
    output logic [15:0]       sweep_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Grid limits in counter width; counters stop at these, never wrap.
    localparam logic [X_bits-1:0] X_MAX     = X_bits'(PIXELS_X - 1);
    localparam logic [Y_bits-1:0] Y_MAX     = Y_bits'(PIXELS_Y - 1);
    localparam logic [3:0]        HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t            state_q, state_d;
    logic [X_bits-1:0] x_q, x_d;
    logic [Y_bits-1:0] y_q, y_d;
    logic [3:0]        hold_q, hold_d;
    logic [X_bits-1:0] wloc_x_q, wloc_x_d;
    logic [Y_bits-1:0] wloc_y_q, wloc_y_d;
    logic              wloc_sugar_q, wloc_sugar_d;

    // State and datapath registers; reset may land mid-sweep.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            hold_q       <= '0;
            wloc_x_q     <= '0;
            wloc_y_q     <= '0;
            wloc_sugar_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hold_q       <= hold_d;
            wloc_x_q     <= wloc_x_d;
            wloc_y_q     <= wloc_y_d;
            wloc_sugar_q <= wloc_sugar_d;
        end
    end

    // Next-state: abort beats everything; pause freezes FETCH/WRITE in place.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        hold_d       = hold_q;
        wloc_x_d     = wloc_x_q;
        wloc_y_d     = wloc_y_q;
        wloc_sugar_d = wloc_sugar_q;
        if (abort) begin
            state_d = ST_IDLE;
            x_d     = '0;
            y_d     = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_FETCH;
                        x_d     = '0;
                        y_d     = '0;
                        hold_d  = '0;
                    end
                end
                ST_FETCH: begin
                    if (!pause) begin
                        state_d      = ST_WRITE;
                        wloc_x_d     = x_q;
                        wloc_y_d     = y_q;
                        wloc_sugar_d = rd_sugar;
                        hold_d       = '0;
                    end
                end
                ST_WRITE: begin
                    if (!pause) begin
                        if (hold_q == HOLD_LAST) begin
                            hold_d = '0;
                            if (x_q == X_MAX && y_q == Y_MAX) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_FETCH;
                                if (x_q == X_MAX) begin
                                    x_d = '0;
                                    y_d = y_q + 1'b1;
                                end else begin
                                    x_d = x_q + 1'b1;
                                end
                            end
                        end else begin
                            hold_d = hold_q + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from registers so reset clears them at once.
    always_comb begin
        rd_x           = x_q;
        rd_y           = y_q;
        write_flag     = (state_q == ST_WRITE) && !pause;
        writeLoc_x     = wloc_x_q;
        writeLoc_y     = wloc_y_q;
        writeLoc_sugar = wloc_sugar_q;
        busy           = (state_q != ST_IDLE);
        done           = (state_q == ST_DONE);
    end

`ifdef SCAN_FRAME_COUNT_EN
    logic [15:0] count_q, count_d;

    // Completed sweeps; bumps once per DONE cycle and wraps naturally.
    always_comb begin
        count_d = count_q;
        if (state_q == ST_DONE) begin
            count_d = count_q + 16'd1;
        end
    end

    // Sweep counter register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign sweep_count = count_q;
`endif

endmodule
